// File: rtl/ps2_mouse_decoder_if.sv
// Signal bundle between a PS/2 mouse decoder and its user: the raw PS/2
// lines going in, and the decoded paddle/button/wheel state coming out.
interface ps2_mouse_decoder_if #(
    parameter int SPEED_W = 8
);
    logic               ps2_clk;
    logic               ps2_data;
    logic               paddle_dir;
    logic [SPEED_W-1:0] paddle_speed;
    logic [2:0]         buttons;
    logic [3:0]         wheel;
    logic               new_output_flag;
    logic               error_flag;
    logic [1:0]         error_code;

    // Side that owns the PS/2 lines and consumes the decoded results.
    modport master (
        output ps2_clk,
        output ps2_data,
        input  paddle_dir,
        input  paddle_speed,
        input  buttons,
        input  wheel,
        input  new_output_flag,
        input  error_flag,
        input  error_code
    );

    // The decoder itself.
    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output paddle_dir,
        output paddle_speed,
        output buttons,
        output wheel,
        output new_output_flag,
        output error_flag,
        output error_code
    );
endinterface

// File: rtl/ps2_mouse_decoder.sv
// PS/2 mouse packet decoder. Synchronises the raw PS/2 lines, deframes
// 11-bit frames, assembles 3- or 4-byte mouse packets and turns one axis
// into a paddle direction plus saturated speed. Errors abort the packet.
module ps2_mouse_decoder #(
    parameter int PACKET_BYTES   = 3,
    parameter int SPEED_W        = 8,
    parameter int AXIS           = 1,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    ps2_mouse_decoder_if.slave   bus
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SPEED_W-1:0] SPEED_MAX  = SPEED_W'((1 << SPEED_W) - 1);
    localparam logic [8:0]         SPEED_MAX9 = 9'((1 << SPEED_W) - 1);
    localparam logic [1:0] LAST_IDX = 2'(PACKET_BYTES - 1);

    localparam logic [1:0] ERR_FRAMING = 2'd0;
    localparam logic [1:0] ERR_PARITY  = 2'd1;
    localparam logic [1:0] ERR_SYNC    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Synchronisers and edge detection
    logic ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_prev_q;
    logic ps2_data_meta_q, ps2_data_sync_q;
    logic fall_c;

    // Frame / packet assembly state
    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_q, parity_d;
    logic [1:0]        byte_index_q, byte_index_d;
    logic [TO_W-1:0]   timeout_q, timeout_d;
    // hdr holds byte0 minus the always-one sync bit:
    // {Y ovf, X ovf, Y sign, X sign, buttons[2:0]}
    logic [6:0]        hdr_q, hdr_d;
    logic [7:0]        x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic [3:0]        z_q, z_d;
    logic              done_c;
    logic              err_c;
    logic [1:0]        err_code_c;
    logic              active_c;

    // Output registers
    logic               dir_q, dir_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [2:0]         buttons_q, buttons_d;
    logic [3:0]         wheel_q, wheel_d;
    logic               new_q, new_d;
    logic               err_flag_q, err_flag_d;
    logic [1:0]         err_code_q, err_code_d;

    // Axis decode helpers
    logic       sign_c;
    logic       ovf_c;
    logic [7:0] mag_byte_c;
    logic [8:0] delta_c;
    logic [8:0] mag_c;

    // Two-flop synchronisers plus a delayed copy of the clock for edge detect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps2_clk_meta_q  <= 1'b1;
            ps2_clk_sync_q  <= 1'b1;
            ps2_clk_prev_q  <= 1'b1;
            ps2_data_meta_q <= 1'b1;
            ps2_data_sync_q <= 1'b1;
        end else begin
            ps2_clk_meta_q  <= bus.ps2_clk;
            ps2_clk_sync_q  <= ps2_clk_meta_q;
            ps2_clk_prev_q  <= ps2_clk_sync_q;
            ps2_data_meta_q <= bus.ps2_data;
            ps2_data_sync_q <= ps2_data_meta_q;
        end
    end

    assign fall_c = ps2_clk_prev_q & ~ps2_clk_sync_q;

    // Frame FSM, packet assembly and timeout state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            byte_index_q <= '0;
            timeout_q    <= '0;
            hdr_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            z_q          <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            byte_index_q <= byte_index_d;
            timeout_q    <= timeout_d;
            hdr_q        <= hdr_d;
            x_q          <= x_d;
            y_q          <= y_d;
            z_q          <= z_d;
        end
    end

    assign active_c = (state_q != S_IDLE) || (byte_index_q != 2'd0);

    // Frame FSM next state: deframing, byte checks, packet assembly, timeout
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        byte_index_d = byte_index_q;
        timeout_d    = timeout_q;
        hdr_d        = hdr_q;
        x_d          = x_q;
        y_d          = y_q;
        z_d          = z_q;
        done_c       = 1'b0;
        err_c        = 1'b0;
        err_code_c   = ERR_FRAMING;

        if (fall_c) begin
            // Any PS/2 clock edge restarts the inactivity window, even one
            // that coincides with expiry.
            timeout_d = '0;
            unique case (state_q)
                S_IDLE: begin
                    if (!ps2_data_sync_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        err_c      = 1'b1;
                        err_code_c = ERR_FRAMING;
                    end
                end
                S_DATA: begin
                    shift_d   = {ps2_data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    parity_d = ps2_data_sync_q;
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!ps2_data_sync_q) begin
                        err_c      = 1'b1;
                        err_code_c = ERR_FRAMING;
                    end else if (^{shift_q, parity_q} == 1'b0) begin
                        err_c      = 1'b1;
                        err_code_c = ERR_PARITY;
                    end else if ((byte_index_q == 2'd0) && !shift_q[3]) begin
                        err_c      = 1'b1;
                        err_code_c = ERR_SYNC;
                    end else begin
                        unique case (byte_index_q)
                            2'd0:    hdr_d = {shift_q[7:4], shift_q[2:0]};
                            2'd1:    x_d   = shift_q;
                            2'd2:    y_d   = shift_q;
                            default: z_d   = shift_q[3:0];
                        endcase
                        if (byte_index_q == LAST_IDX) begin
                            byte_index_d = 2'd0;
                            done_c       = 1'b1;
                        end else begin
                            byte_index_d = byte_index_q + 2'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (active_c) begin
            if (timeout_q == TO_W'(TIMEOUT_CYCLES)) begin
                err_c      = 1'b1;
                err_code_c = ERR_TIMEOUT;
            end else begin
                timeout_d = timeout_q + 1'b1;
            end
        end else begin
            timeout_d = '0;
        end

        // Every error drops the partial packet and parks the FSM.
        if (err_c) begin
            state_d      = S_IDLE;
            byte_index_d = 2'd0;
            timeout_d    = '0;
        end
    end

    // Output next state: decode the completed packet or latch an error
    always_comb begin
        dir_d      = dir_q;
        speed_d    = speed_q;
        buttons_d  = buttons_q;
        wheel_d    = wheel_q;
        new_d      = 1'b0;
        err_flag_d = err_flag_q;
        err_code_d = err_code_q;

        sign_c     = (AXIS == 1) ? hdr_d[4] : hdr_d[3];
        ovf_c      = (AXIS == 1) ? hdr_d[6] : hdr_d[5];
        mag_byte_c = (AXIS == 1) ? y_d : x_d;
        delta_c    = {sign_c, mag_byte_c};
        // 9-bit two's complement negate: -256 maps to 9'h100, i.e. 256.
        mag_c      = sign_c ? (9'd0 - delta_c) : delta_c;

        if (err_c) begin
            err_flag_d = 1'b1;
            err_code_d = err_code_c;
        end else if (done_c) begin
            dir_d      = sign_c;
            speed_d    = (ovf_c || (mag_c > SPEED_MAX9)) ? SPEED_MAX : mag_c[SPEED_W-1:0];
            buttons_d  = hdr_d[2:0];
            wheel_d    = (PACKET_BYTES == 4) ? z_d : 4'd0;
            new_d      = 1'b1;
            err_flag_d = 1'b0;
        end
    end

    // Output register bank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_q      <= 1'b0;
            speed_q    <= '0;
            buttons_q  <= '0;
            wheel_q    <= '0;
            new_q      <= 1'b0;
            err_flag_q <= 1'b0;
            err_code_q <= '0;
        end else begin
            dir_q      <= dir_d;
            speed_q    <= speed_d;
            buttons_q  <= buttons_d;
            wheel_q    <= wheel_d;
            new_q      <= new_d;
            err_flag_q <= err_flag_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.paddle_dir      = dir_q;
    assign bus.paddle_speed    = speed_q;
    assign bus.buttons         = buttons_q;
    assign bus.wheel           = wheel_q;
    assign bus.new_output_flag = new_q;
    assign bus.error_flag      = err_flag_q;
    assign bus.error_code      = err_code_q;

endmodule

// File: doc/ps2_mouse_decoder.md
PS2_MOUSE_DECODER -- requirements
Module: ps2_mouse_decoder

Interface
REQ-001 The block SHALL have parameter PACKET_BYTES, default 3; bytes per mouse packet, legal values 3 (standard) or 4 (wheel mouse).
REQ-002 The block SHALL have parameter SPEED_W, default 8; paddle_speed width, legal 1..8.
REQ-003 The block SHALL have parameter AXIS, default 1; 0 = paddle driven by X movement, 1 = paddle driven by Y movement.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 50000; clk cycles without a ps2_clk falling edge before a partial packet is aborted.
REQ-005 The block SHALL have port clk, input, 1; the single clock; every register is clocked on its rising edge.
REQ-006 The block SHALL have port reset, input, 1; asynchronous, active-low reset.
REQ-007 The block SHALL have port ps2_clk, input, 1; raw PS/2 clock line, asynchronous to clk.
REQ-008 The block SHALL have port ps2_data, input, 1; raw PS/2 data line, asynchronous to clk.
REQ-009 The block SHALL have port paddle_dir, output, 1; 1 = negative delta on the selected axis.
REQ-010 The block SHALL have port paddle_speed, output, SPEED_W; saturated magnitude of the selected-axis delta.
REQ-011 The block SHALL have port buttons, output, 3; {middle, right, left} from byte 0.
REQ-012 The block SHALL have port wheel, output, 4; signed Z delta from byte 3, held at 0 when PACKET_BYTES=3.
REQ-013 The block SHALL have port new_output_flag, output, 1; one-cycle pulse when outputs update.
REQ-014 The block SHALL have port error_flag, output, 1; sticky error indicator.
REQ-015 The block SHALL have port error_code, output, 2; last error: 0 framing, 1 parity, 2 sync, 3 timeout.

Function
REQ-016 ps2_clk and ps2_data SHALL each pass through a 2-flop synchroniser; a falling edge SHALL be detected as previous synced ps2_clk 1 and current synced ps2_clk 0, with synced ps2_data sampled in that same cycle.
REQ-017 The frame FSM SHALL have states IDLE, DATA, PARITY, STOP; on a falling edge, IDLE->DATA if data=0, else stay IDLE and raise a framing error.
REQ-018 DATA SHALL shift in 8 bits LSB first, then go to PARITY; PARITY SHALL capture 1 bit and go to STOP; STOP SHALL capture 1 bit and return to IDLE.
REQ-019 At STOP, the byte SHALL be accepted only if stop=1 and the 8 data bits plus the parity bit have odd parity; a failed stop check SHALL be a framing error (checked first), a failed parity check a parity error.
REQ-020 byte_index SHALL run 0..PACKET_BYTES-1; an accepted byte 0 with bit 3 = 0 SHALL be a sync error.
REQ-021 Any error SHALL set error_flag=1, load error_code, discard the partial packet (byte_index=0) and leave the FSM in IDLE.
REQ-022 On acceptance of byte PACKET_BYTES-1, on the next clk edge all data outputs SHALL update and new_output_flag SHALL be 1 for exactly one cycle; error_flag SHALL clear in that same cycle.
REQ-023 The selected-axis delta SHALL be the 9-bit signed value {byte0 bit4 (X) or bit5 (Y), byte1 (X) or byte2 (Y)}.
REQ-024 paddle_dir SHALL equal the delta sign bit; a delta of 0 SHALL give paddle_dir=0 and paddle_speed=0.
REQ-025 paddle_speed SHALL be |delta| (0..256), saturated to 2^SPEED_W-1; if the axis overflow bit (byte0 bit6 X, bit7 Y) is set, paddle_speed SHALL be 2^SPEED_W-1.
REQ-026 A timeout counter SHALL run while FSM≠IDLE or byte_index≠0, and SHALL zero on every falling edge.
REQ-027 When the timeout counter reaches TIMEOUT_CYCLES, the block SHALL take a timeout error per REQ-021.
REQ-028 If a falling edge and timeout expiry occur in the same cycle, the edge SHALL win and no timeout SHALL be taken.
REQ-029 Outputs other than new_output_flag SHALL hold their values between packets.

Reset
REQ-030 While reset=0, the block SHALL asynchronously force: FSM IDLE, byte_index 0, timeout counter 0, synchronisers 1.
REQ-031 While reset=0, the block SHALL asynchronously force every output to 0.
REQ-032 Assertion of reset mid-frame SHALL discard all partial data, and no new_output_flag SHALL follow release of reset.

Verification
REQ-033 The bench SHALL cover: default parameters, packet 0x28, 0x00, 0xFB (Y = -5) -> one pulse, paddle_dir=1, paddle_speed=5, buttons=0, error_flag=0.
REQ-034 The bench SHALL cover: byte 1 sent with wrong parity -> error_flag=1, error_code=1, no pulse; the next good packet -> pulse, error_flag=0.
REQ-035 The bench SHALL cover: byte 0 = 0x00 (bit3=0) -> error_code=2, byte_index stays 0; the following valid 3-byte packet is decoded.
REQ-036 The bench SHALL cover: ps2_clk stopped after 2 bytes for TIMEOUT_CYCLES=100 cycles -> error_code=3; a fresh packet then decodes correctly.
REQ-037 The bench SHALL cover: SPEED_W=4, AXIS=0, byte0=0x58 (X overflow set), byte1=0x10 -> paddle_speed=15, paddle_dir=1.
REQ-038 The bench SHALL cover: PACKET_BYTES=4, bytes 0x09, 0x03, 0x00, 0x0F -> buttons=3'b001, wheel=4'hF; reset=0 asserted during byte 2 -> no pulse, all outputs 0.
